// File: rtl/wb_dma_arbiter.sv
// Two-master round-robin Wishbone arbiter: grant one cycle after cyc, combinational datapath.
// Owner is stalled by s_stall or a full outstanding window; a silent slave is aborted after TIMEOUT.
module wb_dma_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic [29:0] m0_adr,
  input  logic [31:0] m0_dat_w,
  input  logic [3:0]  m0_sel,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_stall,
  output logic [31:0] m0_dat_r,
  input  logic [29:0] m1_adr,
  input  logic [31:0] m1_dat_w,
  input  logic [3:0]  m1_sel,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_stall,
  output logic [31:0] m1_dat_r,
  output logic [29:0] s_adr,
  output logic [31:0] s_dat_w,
  output logic [3:0]  s_sel,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  input  logic        s_ack,
  input  logic        s_stall,
  input  logic [31:0] s_dat_r,
  output logic [1:0]  grant,
  output logic        timeout_evt
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, HOLD} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [OW-1:0] out_q, out_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    grant_q, grant_d;

  logic own_vld, own_sel, k_cyc, k_stb, below_cap, ack_vld, tmo_hit, acc;

  assign own_vld   = (state_q == OWN0) || (state_q == OWN1);
  assign own_sel   = (state_q == OWN1);
  assign k_cyc     = own_sel ? m1_cyc : m0_cyc;
  assign k_stb     = own_sel ? m1_stb : m0_stb;
  assign below_cap = out_q < OW'(MAX_OUT);
  assign ack_vld   = s_ack && (out_q != '0);
  assign tmo_hit   = own_vld && (tmo_q == TW'(TIMEOUT));
  assign acc       = s_stb && !s_stall;

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_stall = 1'b1;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_stall = 1'b1;
    m1_dat_r = '0;
    if (own_vld) begin
      s_cyc   = k_cyc;
      s_stb   = k_stb && below_cap;
      s_we    = own_sel ? m1_we    : m0_we;
      s_adr   = own_sel ? m1_adr   : m0_adr;
      s_dat_w = own_sel ? m1_dat_w : m0_dat_w;
      s_sel   = own_sel ? m1_sel   : m0_sel;
      if (own_sel) begin
        m1_stall = s_stall || !below_cap;
        m1_ack   = ack_vld;
        m1_err   = tmo_hit;
        m1_dat_r = s_dat_r;
      end else begin
        m0_stall = s_stall || !below_cap;
        m0_ack   = ack_vld;
        m0_err   = tmo_hit;
        m0_dat_r = s_dat_r;
      end
    end
  end

  assign timeout_evt = tmo_hit;
  assign grant       = grant_q;

  // In HOLD, last_q already names the aborted owner, so it doubles as the hold owner.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        out_d = '0;
        tmo_d = '0;
        if (m0_cyc && m1_cyc) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc)      state_d = OWN0;
        else if (m1_cyc)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (tmo_hit) begin
          state_d = HOLD;
          last_d  = own_sel;
          out_d   = '0;
          tmo_d   = '0;
        end else if (!k_cyc) begin
          state_d = IDLE;
          last_d  = own_sel;
          out_d   = '0;
          tmo_d   = '0;
        end else begin
          out_d = out_q + OW'(acc) - OW'(ack_vld);
          tmo_d = (s_ack || out_d == '0) ? '0 : tmo_q + TW'(1);
        end
      end
      HOLD: begin
        if (!(last_q ? m1_cyc : m0_cyc)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      OWN0:    grant_d = 2'b01;
      OWN1:    grant_d = 2'b10;
      HOLD:    grant_d = last_d ? 2'b10 : 2'b01;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
      tmo_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Bench for wb_dma_arbiter: directed scenarios plus a randomized run against a cycle-level model.
module tb_wb_dma_arbiter;

  localparam int MAXO = 4;
  localparam int TMO  = 8;

  logic        ext_clk = 1'b0;
  logic        ext_rst_n;
  logic [29:0] m0_adr, m1_adr, s_adr;
  logic [31:0] m0_dat_w, m1_dat_w, s_dat_w;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_dat_r, m1_dat_r, s_dat_r;
  logic        s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [1:0]  grant;
  logic        timeout_evt;

  int n_assert = 0;
  int n_fail   = 0;

  wb_dma_arbiter #(.MAX_OUT(MAXO), .TIMEOUT(TMO)) dut (
    .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_cyc(m0_cyc), .m0_stb(m0_stb),
    .m0_we(m0_we), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall), .m0_dat_r(m0_dat_r),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_cyc(m1_cyc), .m1_stb(m1_stb),
    .m1_we(m1_we), .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall), .m1_dat_r(m1_dat_r),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_ack(s_ack), .s_stall(s_stall), .s_dat_r(s_dat_r),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  always #5 ext_clk = ~ext_clk;

  // Reference model: who owns the port, whether it is parked after an abort,
  // how many requests are in flight, and how long the slave has been silent.
  int md_own, md_last, md_outs, md_age;
  bit md_hold;
  logic        e_s_cyc, e_s_stb, e_s_we;
  logic [29:0] e_s_adr;
  logic [31:0] e_s_dat_w, e_dat0, e_dat1;
  logic [3:0]  e_s_sel;
  logic [1:0]  e_ack, e_err, e_stall, e_grant;
  logic        e_evt;

  task automatic model_reset();
    md_own = -1; md_last = 1; md_outs = 0; md_age = 0; md_hold = 0;
  endtask

  task automatic model_eval();
    bit k;
    k = (md_own == 1);
    e_s_cyc = 0; e_s_stb = 0; e_s_we = 0; e_s_adr = '0; e_s_dat_w = '0; e_s_sel = '0;
    e_ack = 2'b00; e_err = 2'b00; e_stall = 2'b11; e_dat0 = '0; e_dat1 = '0; e_evt = 0;
    e_grant = (md_own < 0) ? 2'b00 : (k ? 2'b10 : 2'b01);
    if (md_own >= 0 && !md_hold) begin
      e_s_cyc   = k ? m1_cyc : m0_cyc;
      e_s_stb   = (k ? m1_stb : m0_stb) && (md_outs < MAXO);
      e_s_we    = k ? m1_we : m0_we;
      e_s_adr   = k ? m1_adr : m0_adr;
      e_s_dat_w = k ? m1_dat_w : m0_dat_w;
      e_s_sel   = k ? m1_sel : m0_sel;
      e_stall[k] = s_stall || (md_outs == MAXO);
      e_ack[k]   = s_ack && (md_outs > 0);
      e_err[k]   = (md_age == TMO);
      e_evt      = (md_age == TMO);
      if (k) e_dat1 = s_dat_r; else e_dat0 = s_dat_r;
    end
  endtask

  task automatic model_advance();
    bit own_cyc;
    model_eval();
    own_cyc = (md_own == 1) ? m1_cyc : m0_cyc;
    if (md_own < 0) begin
      if (m0_cyc && m1_cyc) md_own = (md_last == 1) ? 0 : 1;
      else if (m0_cyc)      md_own = 0;
      else if (m1_cyc)      md_own = 1;
      md_outs = 0; md_age = 0;
    end else if (md_hold) begin
      if (!own_cyc) begin md_own = -1; md_hold = 0; end
    end else if (md_age == TMO) begin
      md_hold = 1; md_last = md_own; md_outs = 0; md_age = 0;
    end else if (!own_cyc) begin
      md_last = md_own; md_own = -1; md_outs = 0; md_age = 0;
    end else begin
      md_outs = md_outs + ((e_s_stb && !s_stall) ? 1 : 0) - ((s_ack && md_outs > 0) ? 1 : 0);
      md_age  = (s_ack || md_outs == 0) ? 0 : md_age + 1;
    end
  endtask

  task automatic nxt();
    @(posedge ext_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0; s_stall = 0; s_dat_r = '0;
  endtask

  task automatic do_reset();
    ext_rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge ext_clk);
    @(negedge ext_clk);
    ext_rst_n = 1;
    nxt();
  endtask

  task automatic test_reset();
    ext_rst_n = 0;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 30'h3fff_ffff; m0_dat_w = 32'hffff_ffff;
    m0_sel = 4'hf; m1_cyc = 1; s_ack = 1; s_dat_r = 32'hffff_ffff;
    repeat (2) @(posedge ext_clk);
    #1;
    n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_assert++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_s_ctl: got %b want 000", {s_cyc, s_stb, s_we}); end
    n_assert++; if ({s_adr, s_dat_w, s_sel} !== 66'h0) begin n_fail++; $display("FAIL reset_s_data: got %h want 0", {s_adr, s_dat_w, s_sel}); end
    n_assert++; if ({m0_stall, m1_stall} !== 2'b11) begin n_fail++; $display("FAIL reset_stalls: got %b want 11", {m0_stall, m1_stall}); end
    n_assert++; if ({m0_ack, m1_ack, m0_err, m1_err, timeout_evt} !== 5'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 00000", {m0_ack, m1_ack, m0_err, m1_err, timeout_evt}); end
    n_assert++; if ({m0_dat_r, m1_dat_r} !== 64'h0) begin n_fail++; $display("FAIL reset_dat_r: got %h want 0", {m0_dat_r, m1_dat_r}); end
    @(negedge ext_clk);
    ext_rst_n = 1;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b01) begin n_fail++; $display("FAIL reset_first_tie: got %b want 01", grant); end
    clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 30'h0000100;
    @(negedge ext_clk);
    n_assert++; if ({grant, s_cyc, m0_stall} !== 4'b0001) begin n_fail++; $display("FAIL read_idle: got %b want 0001", {grant, s_cyc, m0_stall}); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b01) begin n_fail++; $display("FAIL read_grant: got %b want 01", grant); end
    n_assert++; if ({s_cyc, s_stb, s_adr} !== {2'b11, 30'h0000100}) begin n_fail++; $display("FAIL read_req: got %h want %h", {s_cyc, s_stb, s_adr}, {2'b11, 30'h0000100}); end
    n_assert++; if ({m0_stall, m1_stall} !== 2'b01) begin n_fail++; $display("FAIL read_stalls: got %b want 01", {m0_stall, m1_stall}); end
    nxt();
    m0_stb = 0;
    nxt();
    s_ack = 1; s_dat_r = 32'hDEADBEEF;
    @(negedge ext_clk);
    n_assert++; if ({m0_ack, m0_dat_r} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL read_ack: got %h want %h", {m0_ack, m0_dat_r}, {1'b1, 32'hDEADBEEF}); end
    n_assert++; if ({m1_ack, m1_stall, m1_dat_r} !== {2'b01, 32'h0}) begin n_fail++; $display("FAIL read_other: got %h want %h", {m1_ack, m1_stall, m1_dat_r}, {2'b01, 32'h0}); end
    nxt();
    s_ack = 0; m0_cyc = 0;
    @(negedge ext_clk);
    n_assert++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL read_release_cyc: got %b want 0", s_cyc); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL read_release_grant: got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_tie_m0: got %b want 01", grant); end
    nxt(); m0_cyc = 0;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rr_dead_cycle: got %b want 00", grant); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rr_handover_m1: got %b want 10", grant); end
    nxt(); m1_cyc = 0;
    nxt(); m0_cyc = 1; m1_cyc = 1;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_tie_after_m1: got %b want 01", grant); end
    nxt(); m0_cyc = 0;
    nxt(); m0_cyc = 1;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rr_tie_after_m0: got %b want 10", grant); end
    nxt(); clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_outstanding_cap();
    int acc_m, acc_s;
    acc_m = 0; acc_s = 0;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 30'h55;
    for (int i = 1; i <= 7; i++) begin
      nxt();
      @(negedge ext_clk);
      if (m1_stb && !m1_stall) acc_m++;
      if (s_stb && !s_stall) acc_s++;
      if (acc_m == 6) m1_stb = 0;
    end
    n_assert++; if (acc_m !== MAXO) begin n_fail++; $display("FAIL cap_master_accepts: got %0d want %0d", acc_m, MAXO); end
    n_assert++; if (acc_s !== MAXO) begin n_fail++; $display("FAIL cap_slave_accepts: got %0d want %0d", acc_s, MAXO); end
    n_assert++; if ({m1_stall, s_stb} !== 2'b10) begin n_fail++; $display("FAIL cap_full_stall: got %b want 10", {m1_stall, s_stb}); end
    nxt();
    s_ack = 1;
    @(negedge ext_clk);
    n_assert++; if ({m1_ack, m1_stall} !== 2'b11) begin n_fail++; $display("FAIL cap_ack_while_full: got %b want 11", {m1_ack, m1_stall}); end
    nxt();
    s_ack = 0;
    @(negedge ext_clk);
    n_assert++; if ({m1_stall, s_stb} !== 2'b01) begin n_fail++; $display("FAIL cap_reopen: got %b want 01", {m1_stall, s_stb}); end
    nxt(); clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 30'h2A; m0_dat_w = 32'hCAFEF00D; m0_sel = 4'hF;
    nxt();
    @(negedge ext_clk);
    n_assert++; if ({s_we, s_dat_w, s_sel, m0_stall} !== {1'b1, 32'hCAFEF00D, 4'hF, 1'b0}) begin n_fail++; $display("FAIL tmo_write_accept: got %h want %h", {s_we, s_dat_w, s_sel, m0_stall}, {1'b1, 32'hCAFEF00D, 4'hF, 1'b0}); end
    nxt();
    m0_stb = 0;
    for (int c = 2; c < 1 + TMO; c++) begin
      @(negedge ext_clk);
      n_assert++; if ({m0_err, timeout_evt} !== 2'b00) begin n_fail++; $display("FAIL tmo_early cycle %0d: got %b want 00", c, {m0_err, timeout_evt}); end
      nxt();
    end
    @(negedge ext_clk);
    n_assert++; if ({m0_err, timeout_evt, m1_err} !== 3'b110) begin n_fail++; $display("FAIL tmo_pulse: got %b want 110", {m0_err, timeout_evt, m1_err}); end
    nxt();
    m1_cyc = 1;
    @(negedge ext_clk);
    n_assert++; if ({s_cyc, grant, m0_stall, m0_err, timeout_evt} !== 6'b001100) begin n_fail++; $display("FAIL tmo_hold: got %b want 001100", {s_cyc, grant, m0_stall, m0_err, timeout_evt}); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tmo_hold_keeps: got %b want 01", grant); end
    nxt();
    m0_cyc = 0;
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tmo_hold_exit: got %b want 00", grant); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tmo_next_owner: got %b want 10", grant); end
    nxt(); clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_spurious_ack();
    do_reset();
    m0_cyc = 1;
    nxt();
    s_ack = 1;
    @(negedge ext_clk);
    n_assert++; if ({m0_ack, m1_ack} !== 2'b00) begin n_fail++; $display("FAIL spur_ack_1: got %b want 00", {m0_ack, m1_ack}); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL spur_ack_2: got %b want 0", m0_ack); end
    nxt();
    s_ack = 0; m0_stb = 1;
    @(negedge ext_clk);
    n_assert++; if ({m0_stall, s_stb} !== 2'b01) begin n_fail++; $display("FAIL spur_no_underflow: got %b want 01", {m0_stall, s_stb}); end
    nxt();
    m0_stb = 0; s_ack = 1;
    @(negedge ext_clk);
    n_assert++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL spur_real_ack: got %b want 1", m0_ack); end
    nxt();
    @(negedge ext_clk);
    n_assert++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL spur_extra_ack: got %b want 0", m0_ack); end
    nxt(); clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_async_reset();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    repeat (3) nxt();
    nxt();
    m0_stb = 0;
    @(negedge ext_clk);
    n_assert++; if ({s_cyc, grant} !== 3'b101) begin n_fail++; $display("FAIL arst_before: got %b want 101", {s_cyc, grant}); end
    #2;
    ext_rst_n = 0;
    #1;
    n_assert++; if ({s_cyc, grant, m0_stall} !== 4'b0001) begin n_fail++; $display("FAIL arst_immediate: got %b want 0001", {s_cyc, grant, m0_stall}); end
    @(posedge ext_clk);
    @(negedge ext_clk);
    ext_rst_n = 1;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
    nxt();
    @(negedge ext_clk);
    n_assert++; if ({grant, s_cyc, s_stb, m1_stall} !== 5'b10110) begin n_fail++; $display("FAIL arst_fresh_m1: got %b want 10110", {grant, s_cyc, s_stb, m1_stall}); end
    nxt(); clear_inputs();
    nxt(); nxt();
  endtask

  task automatic test_random();
    bit dead;
    dead = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) m0_cyc = !m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = !m1_cyc;
      m0_stb = m0_cyc && ($urandom_range(0, 1) == 1);
      m1_stb = m1_cyc && ($urandom_range(0, 1) == 1);
      m0_we = ($urandom_range(0, 1) == 1); m1_we = ($urandom_range(0, 1) == 1);
      m0_adr = 30'($urandom); m1_adr = 30'($urandom);
      m0_dat_w = $urandom; m1_dat_w = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      if ($urandom_range(0, 19) == 0) dead = !dead;
      s_ack = !dead && ($urandom_range(0, 9) < 4);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat_r = $urandom;
      @(negedge ext_clk);
      model_eval();
      n_assert++; if ({s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel} !== {e_s_cyc, e_s_stb, e_s_we, e_s_adr, e_s_dat_w, e_s_sel}) begin n_fail++; $display("FAIL rand_slave cycle %0d: got %h want %h", i, {s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel}, {e_s_cyc, e_s_stb, e_s_we, e_s_adr, e_s_dat_w, e_s_sel}); end
      n_assert++; if ({m0_ack, m0_err, m0_stall, m0_dat_r} !== {e_ack[0], e_err[0], e_stall[0], e_dat0}) begin n_fail++; $display("FAIL rand_m0 cycle %0d: got %h want %h", i, {m0_ack, m0_err, m0_stall, m0_dat_r}, {e_ack[0], e_err[0], e_stall[0], e_dat0}); end
      n_assert++; if ({m1_ack, m1_err, m1_stall, m1_dat_r} !== {e_ack[1], e_err[1], e_stall[1], e_dat1}) begin n_fail++; $display("FAIL rand_m1 cycle %0d: got %h want %h", i, {m1_ack, m1_err, m1_stall, m1_dat_r}, {e_ack[1], e_err[1], e_stall[1], e_dat1}); end
      n_assert++; if ({grant, timeout_evt} !== {e_grant, e_evt}) begin n_fail++; $display("FAIL rand_grant_evt cycle %0d: got %b want %b", i, {grant, timeout_evt}, {e_grant, e_evt}); end
      @(posedge ext_clk);
      model_advance();
      #1;
    end
    clear_inputs();
    nxt(); nxt();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ext_rst_n = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_outstanding_cap();
    test_timeout();
    test_spurious_ack();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dma_arbiter.md
# wb_dma_arbiter

Two-master round-robin arbiter that shares the SoC's single `wishbone_dma` slave port between two external pipelined Wishbone masters: m0, the hardware debugger bus master, and m1, a secondary DMA engine. It tracks outstanding transfers per grant and aborts a stuck slave with an error after a programmable ack timeout. It sits between the masters and the `wishbone_dma_out` / `wishbone_dma_in` ports of the Microwatt `soc`.

## Interface
- `MAX_OUT`, default 4: maximum accepted-but-unacked requests per grant (1..15).
- `TIMEOUT`, default 255: cycles without `s_ack` while outstanding > 0 before the arbiter aborts (1..65535).

Ports:
- `ext_clk` in 1: single clock.
- `ext_rst_n` in 1: reset, asynchronous, active-low.
- `m0_adr` / `m1_adr` in 30: word address.
- `m0_dat_w` / `m1_dat_w` in 32: write data.
- `m0_sel` / `m1_sel` in 4: byte selects.
- `m0_cyc`, `m0_stb`, `m0_we` / `m1_cyc`, `m1_stb`, `m1_we` in 1 each: master cycle, strobe, write enable.
- `m0_ack`, `m0_err`, `m0_stall` / `m1_ack`, `m1_err`, `m1_stall` out 1 each: ack, error and stall returned to each master.
- `m0_dat_r` / `m1_dat_r` out 32: read data.
- `s_adr` out 30, `s_dat_w` out 32, `s_sel` out 4, `s_cyc` / `s_stb` / `s_we` out 1: to `wishbone_dma_out`.
- `s_ack` in 1, `s_stall` in 1, `s_dat_r` in 32: from `wishbone_dma_in`.
- `grant` out 2: one-hot owner (bit0 = m0).
- `timeout_evt` out 1: one-cycle pulse on abort.

## Operation
- **States.** IDLE, OWN0, OWN1, HOLD. Registers: state, `last` (last owner served), `outstanding` counter (width fits `MAX_OUT`), and a timeout counter (width fits `TIMEOUT`).
- **IDLE.**
  - `s_cyc` = `s_stb` = 0, both stalls = 1.
  - Only `mk_cyc` high → next state OWNk.
  - Both high → the master ≠ `last` wins.
- **OWNk, slave outputs.** `s_adr`, `s_dat_w`, `s_sel`, `s_we` pass through combinationally from mk. `s_cyc` = `mk_cyc`. `s_stb` = `mk_stb` & (`outstanding` < `MAX_OUT`).
- **OWNk, owner responses.**
  - `mk_stall` = `s_stall` | (`outstanding` == `MAX_OUT`).
  - `mk_ack` = `s_ack` & (`outstanding` ≠ 0).
  - `mk_dat_r` = `s_dat_r`.
- **Non-owner (all states).** `stall` = 1, `ack` = `err` = 0, `dat_r` = 0.
- **Outstanding counter.**
  - accept = `s_stb` & ~`s_stall`.
  - `outstanding` += accept − (`s_ack` & `outstanding` ≠ 0).
  - Simultaneous accept and ack leaves it unchanged.
  - An ack arriving with `outstanding` == 0 is dropped and never underflows the counter.
- **Owner release.** `mk_cyc` falling in OWNk ends the grant: next state IDLE, `last` ← k, `outstanding` ← 0. Because `s_cyc` follows `mk_cyc`, early release is a Wishbone abort to the slave.
- **Timeout.**
  - The counter clears on any `s_ack`, on entry to OWNk, and whenever `outstanding` == 0.
  - Otherwise, in OWNk, it increments each cycle.
  - When it reaches `TIMEOUT`:
    - pulse `mk_err` and `timeout_evt` for 1 cycle;
    - clear `outstanding`;
    - next state HOLD.
- **HOLD.**
  - `s_cyc` = 0; owner stall = 1; `grant` keeps the owner bit.
  - Stay until `mk_cyc` = 0, then IDLE with `last` ← k.
- **Mid-operation reset.** Asynchronous: all state is cleared immediately and `s_cyc` drops in the same cycle.

## Timing
- **Reset values.**
  - state = IDLE, `last` = 1 (m0 wins the first tie), counters = 0, `grant` = 00.
  - `s_cyc` = `s_stb` = `s_we` = 0; `s_adr`, `s_dat_w`, `s_sel` = 0.
  - `m0_stall` = `m1_stall` = 1; acks, errs, `dat_r` and `timeout_evt` = 0.
- **Combinational paths.** All `s_*` and `mk_*` outputs are combinational from the state register and inputs. `grant` is registered (decode of state).
- **Grant latency.** `mk_cyc` rises in cycle N while IDLE → `grant` and `s_cyc` high in N+1. The first request can be accepted in N+1.
- **Handover.** Owner drops `cyc` in cycle N → IDLE in N+1 → the other master is granted in N+2. Minimum 1 dead cycle.
- **Ack forwarding.** Zero-cycle, same-cycle pass-through to the owner.
- **Timeout detection.** With no acks, `err` is asserted in the cycle the counter equals `TIMEOUT`, i.e. `TIMEOUT` cycles after the last ack or first accept.

## Test plan
- **Single m0 read.** m0 asserts cyc/stb at adr `0x0000100`; slave acks 2 cycles later with `0xDEADBEEF` → `grant` = 01 next cycle, `m0_ack` pulses with `m0_dat_r` = `0xDEADBEEF`, `m1_stall` stays 1.
- **Tie and round-robin.** Both masters raise cyc simultaneously out of reset → m0 granted first. m0 releases → m1 granted 2 cycles later. Both request again → m0 wins (`last` = m1).
- **Outstanding cap.** m1 issues 6 back-to-back stb with the slave never stalling and acks held off → exactly 4 accepted, `m1_stall` = 1 while `outstanding` = 4. One ack → one more accepted.
- **Timeout, `TIMEOUT` = 8.** m0 issues a write and the slave never acks → `m0_err` and `timeout_evt` pulse exactly 8 cycles after accept, `s_cyc` = 0, state HOLD until `m0_cyc` falls.
- **Spurious ack.** Slave asserts `s_ack` while `outstanding` = 0 → no `mk_ack`, counter stays 0.
- **Async reset mid-burst.** `ext_rst_n` goes low during 3 outstanding reads → `s_cyc` = 0 immediately, `grant` = 00. After release, a fresh m1 request is granted normally.
